// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  localparam int ARB_N_REQ     = 4;
  localparam int ARB_DATA_W    = 8;
  localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns the first requester
// found searching upward from last+1, wrapping around to last itself.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = ARB_N_REQ,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // Walk candidates from farthest (last itself) to nearest (last+1) so the
  // nearest requester is the one left standing in idx.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips one would infer a latch.
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the FIFO write port among N_REQ producers with
// round-robin grants of at most MAX_BURST beats, stalling on fifo_full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = ARB_N_REQ,
  parameter  int DATA_W    = ARB_DATA_W,
  parameter  int MAX_BURST = ARB_MAX_BURST,
  localparam int IDX_W     = $clog2(N_REQ),
  localparam int CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    fifo_full,
  output logic                    fifo_write,
  output logic [DATA_W-1:0]       fifo_datain,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy
);

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] last_owner, last_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             accept;
  logic             last_beat;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .last  (last_owner),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Write-side outputs are decoded straight from state and inputs so that
  // reset clears them immediately and fifo_full acts within the same cycle.
  assign busy        = (state == ARB_OWN);
  assign accept      = busy & req[owner] & ~fifo_full;
  assign fifo_write  = accept;
  assign ack         = accept ? (N_REQ'(1) << owner) : '0;
  assign fifo_datain = data[owner*DATA_W +: DATA_W];
  assign grant_id    = owner;
  assign last_beat   = (beat_cnt == CNT_W'(MAX_BURST - 1));

  // Next-state decision: arbitrate in IDLE, count/stall/release in OWN.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = beat_cnt;
    last_nxt  = last_owner;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_nxt = ARB_OWN;
          owner_nxt = pick_idx;
          cnt_nxt   = '0;
        end
      end
      ARB_OWN: begin
        if (!req[owner]) begin
          state_nxt = ARB_IDLE;
          last_nxt  = owner;
        end else if (accept && last_beat) begin
          state_nxt = ARB_IDLE;
          last_nxt  = owner;
        end else if (accept) begin
          cnt_nxt = beat_cnt + 1'b1;
        end
        // Otherwise fifo_full is stalling the owner: hold owner and count.
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // State, owner, burst count and round-robin pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (reset) begin
      state      <= ARB_IDLE;
      owner      <= '0;
      beat_cnt   <= '0;
      last_owner <= IDX_W'(N_REQ - 1);
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      beat_cnt   <= cnt_nxt;
      last_owner <= last_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues drive req/data, a FIFO level
// model drives fifo_full, and a scoreboard of predicted (owner, beat) pairs
// is compared against every fifo_write seen mid-cycle.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req;
  logic [N*W-1:0] data;
  logic [N-1:0] ack;
  logic         fifo_full;
  logic         fifo_write;
  logic [W-1:0] fifo_datain;
  logic [1:0]   grant_id;
  logic         busy;

  logic full_force = 1'b0;
  logic model_en   = 1'b0;
  int   level      = 0;

  logic [7:0] src_mem [N][128];
  int         src_head [N];
  int         src_tail [N];
  exp_t       exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  logic         s_write, s_busy;
  logic [N-1:0] s_ack;
  logic [1:0]   s_gid;
  logic [W-1:0] s_data;

  assign fifo_full = full_force | (model_en && level >= DEPTH);

  always #5 clock = ~clock;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .fifo_full   (fifo_full),
    .fifo_write  (fifo_write),
    .fifo_datain (fifo_datain),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  task automatic push_src(input int id, input logic [7:0] val);
    src_mem[id][src_tail[id]] = val;
    src_tail[id]++;
  endtask

  task automatic expect_beat(input int id, input logic [7:0] val);
    exp_t e;
    e.id = 2'(id);
    e.d  = val;
    exp_q.push_back(e);
  endtask

  function automatic logic src_pending();
    logic p = 1'b0;
    for (int i = 0; i < N; i++) if (src_head[i] < src_tail[i]) p = 1'b1;
    return p;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_head[i] < src_tail[i]) begin
        req[i]         = 1'b1;
        data[i*W +: W] = src_mem[i][src_head[i]];
      end else begin
        req[i]         = 1'b0;
        data[i*W +: W] = '0;
      end
    end
  endtask

  // One clock: sample and score at negedge, then advance producers and the
  // FIFO level just after the rising edge.
  task automatic tick();
    exp_t         e;
    logic [N-1:0] exp_ack;
    @(negedge clock);
    s_write = fifo_write;
    s_ack   = ack;
    s_busy  = busy;
    s_gid   = grant_id;
    s_data  = fifo_datain;
    n_checks++;
    if (s_write) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_extra: write id=%0d data=%h, required no write", s_gid, s_data);
      end else begin
        e = exp_q.pop_front();
        exp_ack = '0;
        exp_ack[e.id] = 1'b1;
        if (s_gid !== e.id || s_data !== e.d || s_ack !== exp_ack) begin
          n_fail++;
          $display("FAIL scoreboard_beat: got id=%0d data=%h ack=%b, required id=%0d data=%h ack=%b",
                   s_gid, s_data, s_ack, e.id, e.d, exp_ack);
        end
      end
    end else if (s_ack !== '0) begin
      n_fail++;
      $display("FAIL ack_without_write: ack=%b, required 0000", s_ack);
    end
    @(posedge clock);
    #1;
    if (s_write && model_en) level++;
    for (int i = 0; i < N; i++) if (s_ack[i] && src_head[i] < src_tail[i]) src_head[i]++;
    drive_inputs();
  endtask

  task automatic drain(input string name, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || s_busy || src_pending()) && t < budget) begin
      tick();
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0 || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats outstanding busy=%b after %0d cycles, required 0 and 0",
               name, exp_q.size(), s_busy, t);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_inputs();
    tick();
    n_checks++;
    if (s_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", s_busy); end
    n_checks++;
    if (s_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b, required 0", s_write); end
    n_checks++;
    if (s_ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b, required 0000", s_ack); end
    n_checks++;
    if (s_gid !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d, required 0", s_gid); end
    reset = 1'b0;
    tick();
    n_checks++;
    if (s_busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: busy=%b, required 0", s_busy); end
  endtask

  task automatic test_single();
    push_src(0, 8'h11); push_src(0, 8'h22); push_src(0, 8'h33);
    expect_beat(0, 8'h11); expect_beat(0, 8'h22); expect_beat(0, 8'h33);
    drive_inputs();
    tick();
    n_checks++;
    if (s_busy !== 1'b0 || s_write !== 1'b0) begin
      n_fail++; $display("FAIL single_arb_idle: busy=%b write=%b, required 0 0", s_busy, s_write);
    end
    for (int t = 0; t < 3; t++) begin
      tick();
      n_checks++;
      if (s_write !== 1'b1) begin n_fail++; $display("FAIL single_beat%0d: write=%b, required 1", t, s_write); end
    end
    tick();
    n_checks++;
    if (s_busy !== 1'b1 || s_write !== 1'b0) begin
      n_fail++; $display("FAIL single_release: busy=%b write=%b, required 1 0", s_busy, s_write);
    end
    tick();
    n_checks++;
    if (s_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: busy=%b, required 0", s_busy); end
  endtask

  task automatic test_round_robin();
    int   wcount = 0;
    logic exp_w;
    do_reset();
    for (int k = 0; k < 8; k++) push_src(0, 8'(k));
    for (int i = 1; i < N; i++) for (int k = 0; k < 4; k++) push_src(i, 8'(i*16 + k));
    for (int g = 0; g < 5; g++) begin
      for (int j = 0; j < MB; j++) begin
        if (g == 4) expect_beat(0, 8'(4 + j));
        else if (g == 0) expect_beat(0, 8'(j));
        else expect_beat(g, 8'(g*16 + j));
      end
    end
    drive_inputs();
    tick();
    n_checks++;
    if (s_write !== 1'b0 || s_busy !== 1'b0) begin
      n_fail++; $display("FAIL rr_first_idle: busy=%b write=%b, required 0 0", s_busy, s_write);
    end
    for (int t = 0; t < 24; t++) begin
      tick();
      exp_w = ((t % 5) != 4);
      n_checks++;
      if (s_write !== exp_w) begin n_fail++; $display("FAIL rr_slot%0d: write=%b, required %b", t, s_write, exp_w); end
      if (s_write === 1'b1) wcount++;
    end
    tick();
    n_checks++;
    if (s_busy !== 1'b0 || s_write !== 1'b0) begin
      n_fail++; $display("FAIL rr_end_idle: busy=%b write=%b, required 0 0", s_busy, s_write);
    end
    n_checks++;
    if (wcount != 20) begin n_fail++; $display("FAIL rr_beat_total: got %0d, required 20", wcount); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_leftover: %0d beats unseen, required 0", exp_q.size()); end
  endtask

  task automatic test_full_stall();
    for (int k = 0; k < 4; k++) begin
      push_src(2, 8'(8'hC0 + k));
      expect_beat(2, 8'(8'hC0 + k));
    end
    drive_inputs();
    tick();
    tick();
    n_checks++;
    if (s_write !== 1'b1 || s_gid !== 2'd2) begin
      n_fail++; $display("FAIL stall_first_beat: write=%b id=%0d, required 1 2", s_write, s_gid);
    end
    full_force = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_checks++;
      if (s_write !== 1'b0 || s_ack !== '0 || s_busy !== 1'b1 || s_gid !== 2'd2) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: write=%b ack=%b busy=%b id=%0d, required 0 0000 1 2",
                 t, s_write, s_ack, s_busy, s_gid);
      end
    end
    full_force = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_checks++;
      if (s_write !== 1'b1 || s_busy !== 1'b1) begin
        n_fail++; $display("FAIL stall_resume%0d: write=%b busy=%b, required 1 1", t, s_write, s_busy);
      end
    end
    tick();
    n_checks++;
    if (s_busy !== 1'b0 || s_write !== 1'b0) begin
      n_fail++; $display("FAIL stall_burst_end: busy=%b write=%b, required 0 0", s_busy, s_write);
    end
  endtask

  task automatic test_drop_req();
    do_reset();
    for (int k = 0; k < 4; k++) push_src(1, 8'(8'hA0 + k));
    expect_beat(1, 8'hA0); expect_beat(1, 8'hA1);
    expect_beat(3, 8'hB0); expect_beat(3, 8'hB1);
    expect_beat(0, 8'hE5);
    drive_inputs();
    tick();
    push_src(3, 8'hB0); push_src(3, 8'hB1); push_src(0, 8'hE5);
    drive_inputs();
    tick();
    tick();
    src_head[1] = src_tail[1];
    drive_inputs();
    tick();
    n_checks++;
    if (s_busy !== 1'b1 || s_write !== 1'b0) begin
      n_fail++; $display("FAIL drop_release: busy=%b write=%b, required 1 0", s_busy, s_write);
    end
    tick();
    n_checks++;
    if (s_busy !== 1'b0) begin n_fail++; $display("FAIL drop_bubble: busy=%b, required 0", s_busy); end
    tick();
    n_checks++;
    if (s_write !== 1'b1 || s_gid !== 2'd3) begin
      n_fail++; $display("FAIL drop_next_owner: write=%b id=%0d, required 1 3", s_write, s_gid);
    end
    drain("drop", 20);
  endtask

  task automatic test_reset_mid_burst();
    for (int k = 0; k < 4; k++) push_src(1, 8'(8'hD0 + k));
    expect_beat(1, 8'hD0);
    drive_inputs();
    tick();
    tick();
    #2;
    n_checks++;
    if (fifo_write !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: write=%b, required 1", fifo_write); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (fifo_write !== 1'b0 || ack !== '0 || busy !== 1'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_async: write=%b ack=%b busy=%b id=%0d, required 0 0000 0 0",
               fifo_write, ack, busy, grant_id);
    end
    push_src(0, 8'hE0); push_src(0, 8'hE1);
    tick();
    tick();
    reset = 1'b0;
    expect_beat(0, 8'hE0); expect_beat(0, 8'hE1);
    expect_beat(1, 8'hD1); expect_beat(1, 8'hD2); expect_beat(1, 8'hD3);
    tick();
    n_checks++;
    if (s_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: busy=%b, required 0", s_busy); end
    tick();
    n_checks++;
    if (s_write !== 1'b1 || s_gid !== 2'd0) begin
      n_fail++; $display("FAIL midrst_first_grant: write=%b id=%0d, required 1 0", s_write, s_gid);
    end
    drain("midrst", 30);
  endtask

  task automatic test_fill();
    int t  = 0;
    int nw = 0;
    for (int k = 0; k < 17; k++) begin
      push_src(0, 8'(k));
      push_src(1, 8'(32 + k));
    end
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < MB; j++) expect_beat(b % 2, 8'((b % 2)*32 + (b / 2)*MB + j));
    expect_beat(0, 8'd16);
    level    = 0;
    model_en = 1'b1;
    drive_inputs();
    while (level < DEPTH && t < 100) begin
      tick();
      t++;
    end
    n_checks++;
    if (level != DEPTH) begin n_fail++; $display("FAIL fill_level: got %0d after %0d cycles, required %0d", level, t, DEPTH); end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_write === 1'b1) nw++;
    end
    n_checks++;
    if (nw != 0) begin n_fail++; $display("FAIL fill_write_while_full: got %0d writes, required 0", nw); end
    level--;
    nw = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_write === 1'b1) nw++;
    end
    n_checks++;
    if (nw != 1) begin n_fail++; $display("FAIL fill_after_read: got %0d writes, required 1", nw); end
    n_checks++;
    if (level != DEPTH) begin n_fail++; $display("FAIL fill_level_refull: got %0d, required %0d", level, DEPTH); end
    model_en = 1'b0;
    expect_beat(1, 8'd48);
    drain("fill", 20);
  endtask

  initial begin
    req  = '0;
    data = '0;
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop_req();
    test_reset_mid_burst();
    test_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the team's 32-entry, 8-bit FIFO among several producers. Each producer presents a request with data. The arbiter grants one producer at a time for a bounded burst and drives the FIFO `write`/`datain` pins while respecting `full`. It sits directly in front of the FIFO's write side; the read side is untouched.

## Interface
Parameters:
- `N_REQ`, default 4: number of producers (2..8).
- `DATA_W`, default 8: beat width; matches the FIFO data width.
- `MAX_BURST`, default 4: maximum accepted beats per grant (1..16).

Ports:
- `clock`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req`, in, `N_REQ`: producer i holds `req[i]` high while it has a beat on its data slice.
- `data`, in, `N_REQ*DATA_W`: producer i data is at `data[i*DATA_W +: DATA_W]`.
- `ack`, out, `N_REQ`: one-hot or zero. `ack[i]`=1 means producer i's beat is written at this edge.
- `fifo_full`, in, 1: FIFO `full` flag.
- `fifo_write`, out, 1: drives FIFO `write`.
- `fifo_datain`, out, `DATA_W`: drives FIFO `datain`.
- `grant_id`, out, `$clog2(N_REQ)`: current owner index; valid while `busy`=1.
- `busy`, out, 1: high in OWN state.

## Operation
- States:
  - IDLE: no owner.
  - OWN: one producer owns the FIFO write port.
- IDLE:
  - If any `req` bit is high, pick the first requester found searching upward (wrapping) from `last_owner+1`.
  - Load `owner`, clear `beat_cnt`, go to OWN.
  - If no `req` bit is high, stay in IDLE.
  - No write occurs in IDLE.
- OWN, accept condition: `accept = req[owner] & ~fifo_full`.
  - `fifo_write = accept`.
  - `ack = accept << owner`.
  - `fifo_datain` = owner's data slice, unconditionally.
- OWN transitions, in priority order:
  1. `req[owner]`=0: go to IDLE. `last_owner <= owner`. No write this cycle.
  2. `accept` and `beat_cnt == MAX_BURST-1`: write the final beat, go to IDLE, `last_owner <= owner`.
  3. `accept`: `beat_cnt <= beat_cnt+1`, stay in OWN.
  4. `fifo_full`, with req still high: stall. Hold owner and count; no write, no ack.
- `beat_cnt` width is `$clog2(MAX_BURST)`, minimum 1. It never exceeds `MAX_BURST-1`.
- Requests from non-owners are ignored until the next IDLE cycle.
- `fifo_write`, `ack` and `busy` are combinational from the state register and inputs, so their reset behaviour is immediate.
- Reset values:
  - state IDLE; `owner` 0; `beat_cnt` 0.
  - `last_owner` = `N_REQ-1`, so producer 0 wins the first arbitration.
  - `fifo_write` 0, `ack` 0, `busy` 0, `grant_id` 0.
  - `fifo_datain` = producer 0's slice; don't-care while `fifo_write`=0.
- Reset asserted mid-burst: the burst is abandoned and all outputs return to reset values asynchronously. A beat whose edge coincides with reset assertion is not acked.

## Timing
- Arbitration latency: request seen in IDLE at edge k; earliest write/ack during cycle k+1, captured at edge k+2.
- Burst throughput: one beat per clock while `req[owner]`=1 and `fifo_full`=0.
- Grant turnover: exactly one IDLE bubble cycle between consecutive grants, including a re-grant to the same producer.
- Full deasserting in the same cycle as a stalled beat: the beat is accepted that cycle. `fifo_full` is sampled combinationally.
- Full rises after the final beat of a burst: the burst has already ended; no interaction.
- Fairness bound: a producer holding `req` waits at most `(N_REQ-1)*(MAX_BURST+1)` cycles plus full-stall cycles before its first ack.

## Structure
- Package `fifo_arb_pkg` holds:
  - the `arb_state_t` enum `{ARB_IDLE, ARB_OWN}`;
  - the default constants `ARB_N_REQ`, `ARB_DATA_W`, `ARB_MAX_BURST`.
- Sub-module `rr_pick`: combinational round-robin priority selector.
  - Inputs: `req[N_REQ]`, `last[$clog2(N_REQ)]`.
  - Outputs: `valid`, `idx`.
  - Instantiated once in the IDLE decision path; reusable on the FIFO read side later.
- Top module: state register, owner/count/`last_owner` registers, data mux, ack decode.

## Test plan
- Reset, then `req`=4'b0001, data0=0x11, 0x22, 0x33: IDLE one cycle, then acks on 3 consecutive cycles; FIFO receives 11, 22, 33; `busy` drops after req falls.
- `req`=4'b1111 held, FIFO never full, `MAX_BURST`=4: grant order 0, 1, 2, 3, 0; each grant 4 beats; 1 bubble between grants; 20 beats total in 24 cycles after the first IDLE.
- Producer 2 owns the port, `fifo_full` forced high for 5 cycles mid-burst: no `fifo_write`/`ack` for 5 cycles; `grant_id` stays 2; `beat_cnt` frozen; burst resumes with the remaining beats.
- Owner drops `req` after 2 of 4 beats while producer 3 requests: IDLE next, then producer 3 is granted; the dropped owner is now `last_owner`.
- Reset asserted in the middle of cycle 2 of a burst: `fifo_write`, `ack`, `busy` go 0 without waiting for a clock edge; after release, producer 0 (if requesting) is granted first.
- Fill the FIFO to 32 entries via 8 full bursts, then keep requesting: no write while full; after one FIFO read, exactly one beat is accepted.
